// File: rtl/pixel_frame_fifo_pkg.sv
// Shared definitions for the pixel output stage: raster defaults, tag layout
// and status register offsets used by the register/status path.
package pixel_frame_fifo_pkg;

  // Raster geometry shared with the processor's line buffers
  localparam int IMG_W_DEF = 32;
  localparam int IMG_H_DEF = 32;
  localparam int PIX_W_DEF = 8;

  // Status register offsets (byte addresses)
  localparam logic [7:0] STAT_LEVEL_OFS = 8'h00;
  localparam logic [7:0] STAT_OVF_OFS   = 8'h04;
  localparam logic [7:0] STAT_FRAME_OFS = 8'h08;

  // Raster tags carried next to each pixel
  typedef struct packed {
    logic eof;
    logic eol;
    logic sol;
  } pix_tag_t;

  localparam int TAG_W = $bits(pix_tag_t);

  // Full FIFO entry at the default pixel width
  typedef struct packed {
    logic                 eof;
    logic                 eol;
    logic                 sol;
    logic [PIX_W_DEF-1:0] pixel;
  } pix_entry_t;

endpackage

// File: rtl/pixel_frame_fifo_fifo.sv
// Generic first-word-fall-through FIFO: the head entry is read straight from
// the storage array at the registered read pointer, so a write into an empty
// FIFO becomes visible the cycle after the write edge (no bypass).
module sync_fifo_fwft
  import pixel_frame_fifo_pkg::*;
#(
  parameter int WIDTH = PIX_W_DEF + TAG_W,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_p0 [DEPTH];
  logic [AW:0]      wr_ptr_p0;
  logic [AW:0]      rd_ptr_p0;
  logic [AW:0]      level_p0;
  logic             wr_ok;
  logic             rd_ok;

  // A write into a full FIFO is only allowed when the head leaves this cycle
  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_ok);

  // Stage p0: storage write (data path, not reset)
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_p0[wr_ptr_p0[AW-1:0]] <= wr_data;
    end
  end

  // Stage p0: pointers and occupancy (control, reset)
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_p0 <= '0;
      rd_ptr_p0 <= '0;
      level_p0  <= '0;
    end else begin
      if (wr_ok) wr_ptr_p0 <= wr_ptr_p0 + 1'b1;
      if (rd_ok) rd_ptr_p0 <= rd_ptr_p0 + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   level_p0 <= level_p0 + 1'b1;
        2'b01:   level_p0 <= level_p0 - 1'b1;
        default: level_p0 <= level_p0;
      endcase
    end
  end

  assign rd_data = mem_p0[rd_ptr_p0[AW-1:0]];
  assign level   = level_p0;
  assign full    = (level_p0 == (AW+1)'(DEPTH));
  assign empty   = (level_p0 == '0);

endmodule

// File: rtl/pixel_frame_fifo.sv
// Output stage of the pixel processor: buffers pixels in an FWFT FIFO, tags
// them with raster position, and reports level/overflow/frame status.
// Optional macro PIXEL_FIFO_OVF_CNT_EN adds a saturating dropped-pixel
// counter on ovf_count; without it ovf_count is constant zero.
module pixel_frame_fifo
  import pixel_frame_fifo_pkg::*;
#(
  parameter int DATA_W   = PIX_W_DEF,
  parameter int DEPTH    = 16,
  parameter int IMG_W    = IMG_W_DEF,
  parameter int IMG_H    = IMG_H_DEF,
  parameter int AFULL_TH = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_W-1:0]         pixel_in,
  input  logic                      valid_in,
  output logic                      ready_out,
  output logic                      afull,
  output logic [DATA_W-1:0]         pixel_out,
  output logic                      sol_out,
  output logic                      eol_out,
  output logic                      eof_out,
  output logic                      valid_out,
  input  logic                      ready_in,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      overflow,
  input  logic                      clear_ovf,
  output logic [15:0]               frame_cnt,
  output logic [15:0]               ovf_count
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int EW = DATA_W + TAG_W;

  logic [CW-1:0]     col_p0;
  logic [RW-1:0]     row_p0;
  logic [15:0]       frame_cnt_p0;
  logic              overflow_p0;
  pix_tag_t          wr_tag;
  pix_tag_t          rd_tag;
  logic [DATA_W-1:0] rd_pix;
  logic [EW-1:0]     rd_entry;
  logic              fifo_full;
  logic              fifo_empty;
  logic [LW-1:0]     fifo_level;
  logic              push;
  logic              pop;
  logic              drop;

  // Upstream is never stalled: a pixel that cannot enter is dropped
  assign pop  = !fifo_empty && ready_in;
  assign push = valid_in && (!fifo_full || pop);
  assign drop = valid_in && !push;

  // Tags derived from the write-side raster position of the next accepted pixel
  always_comb begin
    wr_tag     = '0;
    wr_tag.sol = (col_p0 == '0);
    wr_tag.eol = (col_p0 == CW'(IMG_W - 1));
    wr_tag.eof = wr_tag.eol && (row_p0 == RW'(IMG_H - 1));
  end

  sync_fifo_fwft #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data ({wr_tag, pixel_in}),
    .rd_en   (pop),
    .rd_data (rd_entry),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Stage p0: raster counters advance only on accepted pixels
  always_ff @(posedge clk) begin
    if (rst) begin
      col_p0 <= '0;
      row_p0 <= '0;
    end else if (push) begin
      if (wr_tag.eol) begin
        col_p0 <= '0;
        row_p0 <= wr_tag.eof ? '0 : row_p0 + 1'b1;
      end else begin
        col_p0 <= col_p0 + 1'b1;
      end
    end
  end

  // Stage p0: completed-frame counter, wraps at 16 bits
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_p0 <= '0;
    end else if (push && wr_tag.eof) begin
      frame_cnt_p0 <= frame_cnt_p0 + 16'd1;
    end
  end

  // Stage p0: sticky overflow, a new drop beats a clear in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_p0 <= 1'b0;
    end else if (drop) begin
      overflow_p0 <= 1'b1;
    end else if (clear_ovf) begin
      overflow_p0 <= 1'b0;
    end
  end

`ifdef PIXEL_FIFO_OVF_CNT_EN
  logic [15:0] ovf_cnt_p0;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Stage p0: dropped-pixel counter, clear plus drop leaves exactly one
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_cnt_p0 <= '0;
    end else if (clear_ovf) begin
      ovf_cnt_p0 <= drop ? 16'd1 : 16'd0;
    end else if (drop) begin
      ovf_cnt_p0 <= sat_inc16(ovf_cnt_p0);
    end
  end

  assign ovf_count = ovf_cnt_p0;
`else
  assign ovf_count = '0;
`endif

  assign {rd_tag, rd_pix} = rd_entry;

  // Head view: storage is not reset, so present zeros while empty
  always_comb begin
    pixel_out = '0;
    sol_out   = 1'b0;
    eol_out   = 1'b0;
    eof_out   = 1'b0;
    if (!fifo_empty) begin
      pixel_out = rd_pix;
      sol_out   = rd_tag.sol;
      eol_out   = rd_tag.eol;
      eof_out   = rd_tag.eof;
    end
  end

  assign valid_out = !fifo_empty;
  assign ready_out = !fifo_full;
  assign afull     = (fifo_level >= LW'(AFULL_TH));
  assign level     = fifo_level;
  assign overflow  = overflow_p0;
  assign frame_cnt = frame_cnt_p0;

endmodule

// File: tb/tb_pixel_frame_fifo.sv
// Directed bench for pixel_frame_fifo: line/frame tagging, overflow, full
// passthrough, mid-frame reset and overflow clear.
module tb_pixel_frame_fifo;

  localparam int DATA_W   = 8;
  localparam int DEPTH    = 16;
  localparam int IMG_W    = 32;
  localparam int IMG_H    = 32;
  localparam int AFULL_TH = 12;
`ifdef PIXEL_FIFO_OVF_CNT_EN
  localparam int OVF_EN = 1;
`else
  localparam int OVF_EN = 0;
`endif

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] pixel_in;
  logic              valid_in;
  logic              ready_out;
  logic              afull;
  logic [DATA_W-1:0] pixel_out;
  logic              sol_out;
  logic              eol_out;
  logic              eof_out;
  logic              valid_out;
  logic              ready_in;
  logic [4:0]        level;
  logic              overflow;
  logic              clear_ovf;
  logic [15:0]       frame_cnt;
  logic [15:0]       ovf_count;

  int n_check = 0;
  int n_pass  = 0;

  pixel_frame_fifo #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .IMG_W    (IMG_W),
    .IMG_H    (IMG_H),
    .AFULL_TH (AFULL_TH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pixel_in  (pixel_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .afull     (afull),
    .pixel_out (pixel_out),
    .sol_out   (sol_out),
    .eol_out   (eol_out),
    .eof_out   (eof_out),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .level     (level),
    .overflow  (overflow),
    .clear_ovf (clear_ovf),
    .frame_cnt (frame_cnt),
    .ovf_count (ovf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    valid_in  = 1'b0;
    ready_in  = 1'b0;
    clear_ovf = 1'b0;
    pixel_in  = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_check++;
    if (valid_out !== 1'b0) $display("FAIL rst_valid: got %0d want 0", valid_out);
    else n_pass++;
    n_check++;
    if (level !== 5'd0) $display("FAIL rst_level: got %0d want 0", level);
    else n_pass++;
    n_check++;
    if (ready_out !== 1'b1) $display("FAIL rst_ready: got %0d want 1", ready_out);
    else n_pass++;
    n_check++;
    if ({afull, overflow} !== 2'b00) $display("FAIL rst_flags: got %b want 00", {afull, overflow});
    else n_pass++;
    n_check++;
    if (frame_cnt !== 16'd0) $display("FAIL rst_frame_cnt: got %0d want 0", frame_cnt);
    else n_pass++;
    n_check++;
    if (ovf_count !== 16'd0) $display("FAIL rst_ovf_count: got %0d want 0", ovf_count);
    else n_pass++;
    n_check++;
    if ({pixel_out, sol_out, eol_out, eof_out} !== 11'd0)
      $display("FAIL rst_head: got %h want 0", {pixel_out, sol_out, eol_out, eof_out});
    else n_pass++;
  endtask

  task automatic test_line();
    do_reset();
    ready_in = 1'b1;
    for (int i = 0; i < IMG_W; i++) begin
      pixel_in = 8'(i);
      valid_in = 1'b1;
      step();
      n_check++;
      if (valid_out !== 1'b1 || pixel_out !== 8'(i))
        $display("FAIL line_pixel[%0d]: got v=%0d p=%0d want v=1 p=%0d", i, valid_out, pixel_out, i);
      else n_pass++;
      n_check++;
      if ({sol_out, eol_out, eof_out} !== {i == 0, i == IMG_W - 1, 1'b0})
        $display("FAIL line_tags[%0d]: got %b want %b", i, {sol_out, eol_out, eof_out},
                 {i == 0, i == IMG_W - 1, 1'b0});
      else n_pass++;
      n_check++;
      if (level !== 5'd1) $display("FAIL line_level[%0d]: got %0d want 1", i, level);
      else n_pass++;
    end
    valid_in = 1'b0;
    step();
    n_check++;
    if (valid_out !== 1'b0 || level !== 5'd0)
      $display("FAIL line_drained: got v=%0d l=%0d want v=0 l=0", valid_out, level);
    else n_pass++;
  endtask

  task automatic test_frame();
    do_reset();
    ready_in = 1'b1;
    for (int f = 1; f <= 2; f++) begin
      for (int i = 0; i < IMG_W * IMG_H; i++) begin
        pixel_in = 8'(i);
        valid_in = 1'b1;
        step();
        n_check++;
        if (pixel_out !== 8'(i) || eof_out !== (i == IMG_W * IMG_H - 1))
          $display("FAIL frame%0d_px[%0d]: got p=%0d eof=%0d want p=%0d eof=%0d", f, i,
                   pixel_out, eof_out, i[7:0], (i == IMG_W * IMG_H - 1));
        else n_pass++;
        if (i == 0) begin
          n_check++;
          if (sol_out !== 1'b1) $display("FAIL frame%0d_sol: got %0d want 1", f, sol_out);
          else n_pass++;
        end
      end
      n_check++;
      if (frame_cnt !== 16'(f)) $display("FAIL frame_cnt%0d: got %0d want %0d", f, frame_cnt, f);
      else n_pass++;
    end
    valid_in = 1'b0;
    step();
  endtask

  task automatic test_overflow();
    int exp_lvl;
    do_reset();
    ready_in = 1'b0;
    for (int i = 0; i < 20; i++) begin
      pixel_in = 8'(i);
      valid_in = 1'b1;
      step();
      exp_lvl = (i + 1 > DEPTH) ? DEPTH : i + 1;
      n_check++;
      if (level !== 5'(exp_lvl) || afull !== (exp_lvl >= AFULL_TH) || ready_out !== (exp_lvl < DEPTH))
        $display("FAIL ovf_fill[%0d]: got l=%0d af=%0d rdy=%0d want l=%0d af=%0d rdy=%0d", i,
                 level, afull, ready_out, exp_lvl, (exp_lvl >= AFULL_TH), (exp_lvl < DEPTH));
      else n_pass++;
      if (i == DEPTH - 1) begin
        n_check++;
        if (overflow !== 1'b0) $display("FAIL ovf_early: got %0d want 0", overflow);
        else n_pass++;
      end
    end
    valid_in = 1'b0;
    n_check++;
    if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %0d want 1", overflow);
    else n_pass++;
    n_check++;
    if (ovf_count !== 16'(OVF_EN * 4)) $display("FAIL ovf_count4: got %0d want %0d", ovf_count, OVF_EN * 4);
    else n_pass++;
    ready_in = 1'b1;
    for (int j = 0; j < DEPTH; j++) begin
      n_check++;
      if (valid_out !== 1'b1 || pixel_out !== 8'(j))
        $display("FAIL ovf_drain[%0d]: got v=%0d p=%0d want v=1 p=%0d", j, valid_out, pixel_out, j);
      else n_pass++;
      step();
    end
    n_check++;
    if (valid_out !== 1'b0 || level !== 5'd0)
      $display("FAIL ovf_empty: got v=%0d l=%0d want v=0 l=0", valid_out, level);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    ready_in = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      pixel_in = 8'(i);
      valid_in = 1'b1;
      step();
    end
    ready_in = 1'b1;
    for (int k = 0; k < 10; k++) begin
      pixel_in = 8'(DEPTH + k);
      valid_in = 1'b1;
      n_check++;
      if (pixel_out !== 8'(k)) $display("FAIL b2b_head[%0d]: got %0d want %0d", k, pixel_out, k);
      else n_pass++;
      step();
      n_check++;
      if (level !== 5'd16) $display("FAIL b2b_level[%0d]: got %0d want 16", k, level);
      else n_pass++;
    end
    valid_in = 1'b0;
    n_check++;
    if (overflow !== 1'b0) $display("FAIL b2b_no_drop: got %0d want 0", overflow);
    else n_pass++;
    for (int k = 10; k < DEPTH + 10; k++) begin
      n_check++;
      if (valid_out !== 1'b1 || pixel_out !== 8'(k))
        $display("FAIL b2b_drain[%0d]: got v=%0d p=%0d want v=1 p=%0d", k, valid_out, pixel_out, k);
      else n_pass++;
      step();
    end
    n_check++;
    if (valid_out !== 1'b0) $display("FAIL b2b_empty: got %0d want 0", valid_out);
    else n_pass++;
  endtask

  task automatic test_reset_midframe();
    do_reset();
    ready_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pixel_in = 8'(i);
      valid_in = 1'b1;
      step();
    end
    valid_in = 1'b0;
    step();
    ready_in = 1'b0;
    for (int i = 5; i < 10; i++) begin
      pixel_in = 8'(i);
      valid_in = 1'b1;
      step();
    end
    valid_in = 1'b0;
    n_check++;
    if (level !== 5'd5) $display("FAIL mid_level_pre: got %0d want 5", level);
    else n_pass++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_check++;
    if (level !== 5'd0 || valid_out !== 1'b0)
      $display("FAIL mid_reset: got l=%0d v=%0d want l=0 v=0", level, valid_out);
    else n_pass++;
    pixel_in = 8'hAA;
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    n_check++;
    if (valid_out !== 1'b1 || pixel_out !== 8'hAA || sol_out !== 1'b1)
      $display("FAIL mid_restart: got v=%0d p=%0d sol=%0d want v=1 p=170 sol=1", valid_out, pixel_out, sol_out);
    else n_pass++;
  endtask

  task automatic test_clear_ovf();
    do_reset();
    ready_in = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      pixel_in = 8'(i);
      valid_in = 1'b1;
      step();
    end
    valid_in = 1'b0;
    n_check++;
    if (overflow !== 1'b1 || ovf_count !== 16'(OVF_EN))
      $display("FAIL clr_pre: got o=%0d c=%0d want o=1 c=%0d", overflow, ovf_count, OVF_EN);
    else n_pass++;
    clear_ovf = 1'b1;
    step();
    clear_ovf = 1'b0;
    n_check++;
    if (overflow !== 1'b0 || ovf_count !== 16'd0)
      $display("FAIL clr_plain: got o=%0d c=%0d want o=0 c=0", overflow, ovf_count);
    else n_pass++;
    pixel_in  = 8'h55;
    valid_in  = 1'b1;
    clear_ovf = 1'b1;
    step();
    valid_in  = 1'b0;
    clear_ovf = 1'b0;
    n_check++;
    if (overflow !== 1'b1 || ovf_count !== 16'(OVF_EN))
      $display("FAIL clr_with_drop: got o=%0d c=%0d want o=1 c=%0d", overflow, ovf_count, OVF_EN);
    else n_pass++;
    n_check++;
    if (level !== 5'd16) $display("FAIL clr_level: got %0d want 16", level);
    else n_pass++;
  endtask

  initial begin
    rst       = 1'b1;
    valid_in  = 1'b0;
    ready_in  = 1'b0;
    clear_ovf = 1'b0;
    pixel_in  = '0;
    test_reset();
    test_line();
    test_frame();
    test_overflow();
    test_back_to_back();
    test_reset_midframe();
    test_clear_ovf();
    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule

// File: doc/pixel_frame_fifo.md
Name: pixel_frame_fifo

Overview:
- Downstream stage of the pixel processor. Buffers the processed pixel stream in a first-word-fall-through (FWFT) FIFO.
- Tags each pixel with raster position: start-of-line, end-of-line, end-of-frame.
- Presents the stream to a ready/valid sink (DMA/display writer) and absorbs the processor's non-backpressured valid pulses.
- Reports fill level, sticky overflow and frame count for the register/status path.

Parameters:
- DATA_W, 8, pixel width
- DEPTH, 16, FIFO entries (power of two, >=4)
- IMG_W, 32, pixels per line
- IMG_H, 32, lines per frame
- AFULL_TH, 12, level at or above which afull asserts

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- pixel_in  in  DATA_W  processed pixel from upstream
- valid_in  in  1  upstream pixel valid
- ready_out  out  1  space available (= !full); advisory only, upstream may ignore it
- afull  out  1  level >= AFULL_TH
- pixel_out  out  DATA_W  head-of-FIFO pixel
- sol_out  out  1  head pixel is column 0
- eol_out  out  1  head pixel is column IMG_W-1
- eof_out  out  1  head pixel is last pixel of frame
- valid_out  out  1  FIFO not empty
- ready_in  in  1  sink accepts head
- level  out  $clog2(DEPTH)+1  current occupancy
- overflow  out  1  sticky: a pixel was dropped
- clear_ovf  in  1  clears overflow (and ovf_count)
- frame_cnt  out  16  completed frames written, wraps
- ovf_count  out  16  dropped-pixel count (see Optional Feature)

Behaviour:
- Reset (synchronous, rst=1 at clk edge): all outputs 0 except ready_out=1; level=0, pointers=0, col/row=0, frame_cnt=0, overflow=0. FIFO contents are discarded. Reset mid-frame restarts the raster at (0,0).
- Push = valid_in && (!full || pop). Pop = valid_out && ready_in.
- Each entry stores {eof,eol,sol,pixel}, tags computed from write-side col/row at push time.
- Write-side counters advance only on push:
  - col wraps at IMG_W-1; row increments on col wrap.
  - row wraps at IMG_H-1; frame_cnt++ on the push carrying eof.
  - Dropped pixels do not advance col/row; the raster stays aligned to accepted pixels.
- Latency: pixel pushed at edge N appears on pixel_out with valid_out=1 after edge N (visible cycle N+1) if the FIFO was empty. Outputs are registered/array-read from the registered read pointer, so there is no combinational path from pixel_in to outputs.
- Head data and tags are stable while valid_out && !ready_in.
- Full and push without pop: pixel dropped, overflow<=1, level unchanged.
- Full with simultaneous pop and push: both occur, level stays DEPTH.
- Empty with ready_in=1: no pop. A push into an empty FIFO is not readable the same cycle (no bypass).
- level: +1 on push-only, -1 on pop-only, unchanged on both or neither.
- clear_ovf and a new drop in the same cycle: overflow ends at 1 (set wins).
- Pointers: $clog2(DEPTH) bits plus wrap bit.
- full = (level==DEPTH). empty = (level==0).

Optional Feature:
- Macro PIXEL_FIFO_OVF_CNT_EN.
- Defined: ovf_count is a 16-bit counter incremented on each dropped pixel, saturating at 16'hFFFF, cleared by clear_ovf. If clear and drop occur in the same cycle, the result is 1.
- Undefined: ovf_count tied to 0, and no counter is synthesized.

Decomposition:
- Shared package holds:
  - pixel tag struct {eof,eol,sol,pixel[DATA_W-1:0]}
  - default IMG_W/IMG_H constants (shared with the processor's line-buffer width)
  - the status register offset for level/overflow/frame_cnt
- One natural sub-module: sync_fifo_fwft (generic width/depth storage, pointers, level, full/empty). pixel_frame_fifo wraps it with raster tagging, overflow and frame logic.

Test Plan:
- Reset then push 32 pixels 0..31 with ready_in=1 -> outputs 0..31 in order, each one cycle after its push. sol on pixel 0, eol on pixel 31, eof=0; level peaks at 1.
- Full frame of 1024 pixels with ready_in=1 -> eof_out only on the 1024th output; frame_cnt=1; row/col return to 0. Second frame gives frame_cnt=2.
- ready_in=0, push 20 pixels -> level=16, afull=1 from level 12, ready_out=0. Pixels 16..19 dropped, overflow=1, ovf_count=4 with macro / 0 without. Drain yields pixels 0..15.
- Full FIFO, valid_in=1 and ready_in=1 for 10 cycles -> no drops, level stays 16, output order preserved.
- Assert rst mid-frame at col 10 with level 5 -> next cycle level=0, valid_out=0. The next push carries sol=1 (col 0).
- overflow=1, pulse clear_ovf with no drop -> overflow=0, ovf_count=0. clear_ovf coincident with a drop -> overflow=1, ovf_count=1.
